cmerge_sync: RTL

// Clocked controlled merge: the receiving end of a two-way steered 4-phase bundled-data

---
 rtl/cmerge_sync_if.sv | 28 ++
 rtl/cmerge_sync.sv | 137 +++++++++++++
 2 files changed

// File: rtl/cmerge_sync_if.sv
// Handshake bundle for the controlled merge: control token, two input channels, one output channel.
// slave = the merge itself, master = the surrounding environment.
interface cmerge_sync_if #(
  parameter int N = 1
);
  logic         ctl_a;
  logic         ctl_b;
  logic         actl_i;
  logic         r_i;
  logic         a_i;
  logic [N-1:0] d_i;
  logic         r1_i;
  logic         a1_i;
  logic [N-1:0] d1_i;
  logic         r_o;
  logic         a_o;
  logic [N-1:0] d_o;

  modport slave (
    input  ctl_a, ctl_b, r_i, d_i, r1_i, d1_i, a_o,
    output actl_i, a_i, a1_i, r_o, d_o
  );

  modport master (
    output ctl_a, ctl_b, r_i, d_i, r1_i, d1_i, a_o,
    input  actl_i, a_i, a1_i, r_o, d_o
  );
endinterface

// File: rtl/cmerge_sync.sv
// Clocked controlled merge: a one-hot ctl token picks channel 0 or 1 and forwards it to the output.
// Latency: selected request -> r_o is 1 clk + SYNC; a_o -> ack is 1 clk + SYNC; 4-phase, r_o held until a_o.
module cmerge_sync #(
  parameter int N    = 1,
  parameter int SYNC = 2
) (
  input  logic          clk,
  input  logic          rst,
  cmerge_sync_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_R,
    REQ,
    ACKD,
    REL
  } state_t;

  // Bit order: {a_o, r1_i, r_i, ctl_b, ctl_a}; data is bundled and not synchronised.
  logic [4:0] async_v;
  logic [4:0] sync_v;

  assign async_v = {bus.a_o, bus.r1_i, bus.r_i, bus.ctl_b, bus.ctl_a};

  generate
    if (SYNC == 0) begin : g_nosync
      assign sync_v = async_v;
    end else begin : g_sync
      logic [4:0] stg [SYNC];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < SYNC; k++) stg[k] <= '0;
        end else begin
          stg[0] <= async_v;
          for (int k = 1; k < SYNC; k++) stg[k] <= stg[k-1];
        end
      end

      assign sync_v = stg[SYNC-1];
    end
  endgenerate

  logic ctl_a_s, ctl_b_s, r0_s, r1_s, a_o_s;
  assign {a_o_s, r1_s, r0_s, ctl_b_s, ctl_a_s} = sync_v;

  state_t       state_q, state_d;
  logic         sel_q, sel_d;
  logic         r_o_q, r_o_d;
  logic         a0_q, a0_d;
  logic         a1_q, a1_d;
  logic         actl_q, actl_d;
  logic [N-1:0] d_o_q, d_o_d;
  logic         sel_r;

  assign sel_r = sel_q ? r1_s : r0_s;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    r_o_d   = r_o_q;
    a0_d    = a0_q;
    a1_d    = a1_q;
    actl_d  = actl_q;
    d_o_d   = d_o_q;
    case (state_q)
      IDLE: begin
        // ctl_a has priority when both token lines are high
        if (ctl_a_s) begin
          sel_d   = 1'b0;
          state_d = WAIT_R;
        end else if (ctl_b_s) begin
          sel_d   = 1'b1;
          state_d = WAIT_R;
        end
      end
      WAIT_R: begin
        if (sel_r) begin
          d_o_d   = sel_q ? bus.d1_i : bus.d_i;
          r_o_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (a_o_s) begin
          a0_d    = ~sel_q;
          a1_d    = sel_q;
          actl_d  = 1'b1;
          state_d = ACKD;
        end
      end
      ACKD: begin
        if (!sel_r && !ctl_a_s && !ctl_b_s) begin
          r_o_d   = 1'b0;
          state_d = REL;
        end
      end
      REL: begin
        if (!a_o_s) begin
          a0_d    = 1'b0;
          a1_d    = 1'b0;
          actl_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      r_o_q   <= 1'b0;
      a0_q    <= 1'b0;
      a1_q    <= 1'b0;
      actl_q  <= 1'b0;
      d_o_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      r_o_q   <= r_o_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      actl_q  <= actl_d;
      d_o_q   <= d_o_d;
    end
  end

  assign bus.r_o    = r_o_q;
  assign bus.a_i    = a0_q;
  assign bus.a1_i   = a1_q;
  assign bus.actl_i = actl_q;
  assign bus.d_o    = d_o_q;

endmodule
